// File: rtl/cordiv_pkg.sv
// Shared defaults and helpers for the multi-lane correlated stochastic divider.
package cordiv_pkg;

    localparam int unsigned ChDef      = 4;
    localparam int unsigned SrDepthDef = 4;
    localparam int unsigned CntWDef    = 8;

    // A full window of ones reaches 2**cntw, so one extra bit is needed.
    function automatic int unsigned est_width(input int unsigned cntw);
        return cntw + 1;
    endfunction

    function automatic int unsigned tap_clamp(input int unsigned sel, input int unsigned depth);
        return (sel >= depth) ? depth - 1 : sel;
    endfunction

endpackage

// File: rtl/cordiv_lane.sv
// One divider lane: quotient shift register, tap mux, quotient select and
// windowed ones-counter with its held estimate.
module cordiv_lane
    import cordiv_pkg::*;
#(
    parameter int unsigned SRDEPTH = SrDepthDef,
    parameter int unsigned CNTW    = CntWDef,
    parameter int unsigned SELW    = $clog2(SRDEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          en,
    input  logic                          win_end,
    input  logic [SELW-1:0]               sel,
    input  logic                          dividend,
    input  logic                          divisor,
    output logic                          quotient,
    output logic                          srout,
    output logic [est_width(CNTW)-1:0]    est
);

    localparam int unsigned EstW = est_width(CNTW);

    logic [SRDEPTH-1:0] r_sr;
    logic [EstW-1:0]    r_acc;
    logic [EstW-1:0]    r_est;
    logic [SELW-1:0]    w_tap;
    logic [EstW-1:0]    w_acc_next;

    assign w_tap      = SELW'(tap_clamp(32'(sel), SRDEPTH));
    assign srout      = r_sr[w_tap];
    // Divisor high passes the dividend; otherwise replay a past quotient bit.
    assign quotient   = divisor ? dividend : srout;
    assign w_acc_next = r_acc + EstW'(quotient);
    assign est        = r_est;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr  <= '0;
            r_acc <= '0;
            r_est <= '0;
        end else if (clr) begin
            r_sr  <= '0;
            r_acc <= '0;
            r_est <= '0;
        end else if (en) begin
            if (divisor) begin
                r_sr <= {r_sr[SRDEPTH-2:0], quotient};
            end
            if (win_end) begin
                r_est <= w_acc_next;
                r_acc <= '0;
            end else begin
                r_acc <= w_acc_next;
            end
        end
    end

endmodule

// File: rtl/cordiv_array.sv
// CH independent CORDIV lanes sharing stream enable, clear and the estimation
// window counter; est_valid pulses once per completed window.
module cordiv_array
    import cordiv_pkg::*;
#(
    parameter int unsigned CH      = ChDef,
    parameter int unsigned SRDEPTH = SrDepthDef,
    parameter int unsigned CNTW    = CntWDef
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clr,
    input  logic                                 en,
    input  logic [CH*$clog2(SRDEPTH)-1:0]        sel,
    input  logic [CH-1:0]                        dividend,
    input  logic [CH-1:0]                        divisor,
    output logic [CH-1:0]                        quotient,
    output logic [CH-1:0]                        srout,
    output logic [CH*est_width(CNTW)-1:0]        est,
    output logic                                 est_valid
);

    localparam int unsigned SELW = $clog2(SRDEPTH);
    localparam int unsigned EstW = est_width(CNTW);

    if (SRDEPTH < 2) begin : g_bad_depth
        $error("cordiv_array: SRDEPTH must be >= 2");
    end
    if (CNTW < 1) begin : g_bad_cntw
        $error("cordiv_array: CNTW must be >= 1");
    end

    logic [CNTW-1:0] r_win_cnt;
    logic            r_est_valid;
    logic            w_win_end;

    assign w_win_end = en && (r_win_cnt == {CNTW{1'b1}});
    assign est_valid = r_est_valid;

    // Counter wraps naturally, so the next window starts on the following en cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_cnt   <= '0;
            r_est_valid <= 1'b0;
        end else if (clr) begin
            r_win_cnt   <= '0;
            r_est_valid <= 1'b0;
        end else begin
            r_est_valid <= w_win_end;
            if (en) begin
                r_win_cnt <= r_win_cnt + CNTW'(1);
            end
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_lane
        cordiv_lane #(
            .SRDEPTH (SRDEPTH),
            .CNTW    (CNTW),
            .SELW    (SELW)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (clr),
            .en       (en),
            .win_end  (w_win_end),
            .sel      (sel[c*SELW +: SELW]),
            .dividend (dividend[c]),
            .divisor  (divisor[c]),
            .quotient (quotient[c]),
            .srout    (srout[c]),
            .est      (est[c*EstW +: EstW])
        );
    end

endmodule

// File: tb/tb_cordiv_array.sv
// Randomised bench for cordiv_array against a queue-based behavioural model.
module tb_cordiv_array;

    localparam int CH      = 4;
    localparam int SRDEPTH = 4;
    localparam int CNTW    = 8;
    localparam int SELW    = 2;
    localparam int EW      = CNTW + 1;
    localparam int WIN     = 1 << CNTW;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               clr;
    logic               en;
    logic [CH*SELW-1:0] sel;
    logic [CH-1:0]      dividend;
    logic [CH-1:0]      divisor;
    logic [CH-1:0]      quotient;
    logic [CH-1:0]      srout;
    logic [CH*EW-1:0]   est;
    logic               est_valid;

    cordiv_array #(
        .CH      (CH),
        .SRDEPTH (SRDEPTH),
        .CNTW    (CNTW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .en        (en),
        .sel       (sel),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .srout     (srout),
        .est       (est),
        .est_valid (est_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: per lane, the history of quotient bits emitted on divisor=1 cycles
    // (newest first), plus a ones-count over windows of WIN enabled cycles.
    bit m_hist [CH][$];
    int m_acc  [CH];
    int m_est  [CH];
    int m_seen;
    bit m_ev;

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            m_hist[c].delete();
            for (int i = 0; i < SRDEPTH; i++) m_hist[c].push_back(1'b0);
            m_acc[c] = 0;
            m_est[c] = 0;
        end
        m_seen = 0;
        m_ev   = 1'b0;
    endfunction

    function automatic int tap_of(input int c);
        int s;
        s = int'(sel[c*SELW +: SELW]);
        return (s > SRDEPTH - 1) ? SRDEPTH - 1 : s;
    endfunction

    function automatic bit exp_q(input int c);
        return divisor[c] ? dividend[c] : m_hist[c][tap_of(c)];
    endfunction

    // One clock: check combinational outputs, clock, advance model, check registers.
    task automatic step();
        bit q [CH];
        bit dv [CH];
        #1;
        for (int c = 0; c < CH; c++) begin
            q[c]  = exp_q(c);
            dv[c] = divisor[c];
            check_eq($sformatf("srout%0d", c), 64'(srout[c]), 64'(m_hist[c][tap_of(c)]));
            check_eq($sformatf("quot%0d", c), 64'(quotient[c]), 64'(q[c]));
        end
        @(posedge clk);
        if (clr) begin
            model_reset();
        end else begin
            m_ev = 1'b0;
            if (en) begin
                for (int c = 0; c < CH; c++) begin
                    if (dv[c]) begin
                        m_hist[c].push_front(q[c]);
                        void'(m_hist[c].pop_back());
                    end
                    m_acc[c] += int'(q[c]);
                end
                m_seen++;
                if (m_seen == WIN) begin
                    for (int c = 0; c < CH; c++) begin
                        m_est[c] = m_acc[c];
                        m_acc[c] = 0;
                    end
                    m_seen = 0;
                    m_ev   = 1'b1;
                end
            end
        end
        #1;
        check_eq("est_valid", 64'(est_valid), 64'(m_ev));
        for (int c = 0; c < CH; c++)
            check_eq($sformatf("est%0d", c), 64'(est[c*EW +: EW]), 64'(m_est[c]));
    endtask

    task automatic run_until_ev(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!est_valid && n < 3 * WIN);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        en  = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic rand_data();
        dividend = CH'($urandom);
        divisor  = CH'($urandom);
    endtask

    int n;
    int ev_seen;
    int sum;
    bit in_range;
    int exp3 [4];

    initial begin
        // 1: reset state and zero-latency quotient
        rst_n = 1'b0; clr = 1'b0; en = 1'b0; sel = '0;
        divisor = 4'hF; dividend = 4'hF;
        #2;
        check_eq("t1_quot", 64'(quotient), 64'hF);
        check_eq("t1_srout", 64'(srout), 64'h0);
        check_eq("t1_est", 64'(est), 64'h0);
        check_eq("t1_ev", 64'(est_valid), 64'h0);
        #1 rst_n = 1'b1;
        divisor = 4'h0;
        #1;
        check_eq("t1_quot0", 64'(quotient), 64'h0);
        model_reset();
        @(posedge clk);
        #1;

        // 2: all-ones window, then all-zeros window after clear
        en = 1'b1; divisor = 4'hF; dividend = 4'hF;
        repeat (WIN) step();
        check_eq("t2_ev", 64'(est_valid), 64'h1);
        for (int c = 0; c < CH; c++)
            check_eq($sformatf("t2_est%0d", c), 64'(est[c*EW +: EW]), 64'h100);
        do_clr();
        divisor = 4'h0; dividend = 4'h0;
        repeat (WIN) step();
        check_eq("t2_ev0", 64'(est_valid), 64'h1);
        check_eq("t2_est_zero", 64'(est), 64'h0);

        // 3: lane0 shift-register contents and tap selection
        do_clr();
        sel = '0;
        divisor = 4'h1; dividend = 4'h1; step();
        dividend = 4'h0; step();
        dividend = 4'h1; step();
        divisor = 4'h0; dividend = 4'h0;
        exp3 = '{1, 0, 1, 0};
        for (int s = 0; s < 4; s++) begin
            sel[SELW-1:0] = SELW'(s);
            #1;
            check_eq($sformatf("t3_tap%0d", s), 64'(srout[0]), 64'(exp3[s]));
            step();
        end
        sel = '0;

        // 4: idle cycles stretch the window
        do_clr();
        repeat (50) begin rand_data(); step(); end
        en = 1'b0;
        repeat (10) begin rand_data(); step(); end
        en = 1'b1;
        rand_data();
        run_until_ev(n);
        check_eq("t4_latency", 64'(60 + n), 64'(WIN + 10));

        // 5: clear mid-window, then reset mid-window
        do_clr();
        repeat (100) begin rand_data(); step(); end
        do_clr();
        check_eq("t5_est_clr", 64'(est), 64'h0);
        check_eq("t5_ev_clr", 64'(est_valid), 64'h0);
        rand_data();
        run_until_ev(n);
        check_eq("t5_clr_latency", 64'(n), 64'(WIN));
        repeat (100) begin rand_data(); step(); end
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
        ev_seen = 0;
        repeat (WIN - 1) begin rand_data(); step(); ev_seen += int'(est_valid); end
        check_eq("t5_no_ev_aborted", 64'(ev_seen), 64'h0);
        step();
        check_eq("t5_ev_after_rst", 64'(est_valid), 64'h1);

        // 6: dividend subset of divisor, ratio about 0.5
        do_clr();
        sel = {CH{2'd1}};
        sum = 0;
        repeat (16 * WIN) begin
            divisor  = CH'($urandom);
            dividend = divisor & CH'($urandom);
            step();
            if (est_valid)
                for (int c = 0; c < CH; c++) sum += int'(est[c*EW +: EW]);
        end
        in_range = (sum >= (128 - 12) * 16 * CH) && (sum <= (128 + 12) * 16 * CH);
        check_eq("t6_mean_range", 64'(in_range), 64'h1);

        // Mixed random: en, clr, sel all varying
        repeat (2000) begin
            rand_data();
            sel = CH*SELW'($urandom);
            en  = ($urandom_range(3) != 0);
            clr = ($urandom_range(63) == 0);
            step();
        end
        clr = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
